full_tap_loader: RTL



---
 rtl/full_tap_loader_pkg.sv | 20 ++
 rtl/full_skid_buf.sv | 65 ++++++
 rtl/full_tap_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/full_tap_loader_pkg.sv
// Shared types for the tap loader slice.
//   float_24_8              : 32-bit tap word (24-bit mantissa / 8-bit exponent container)
//   tap_beat_t              : payload carried through the skid buffer (word + first-tap flag)
//   full_tap_loader_state_t : loader FSM states
package full_tap_loader_pkg;

   typedef logic [31:0] float_24_8;

   typedef struct packed {
      float_24_8 data;
      logic      fst;
   } tap_beat_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } full_tap_loader_state_t;

endpackage

// File: rtl/full_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
//   T        : payload type
//   clk      : clock
//   reset    : asynchronous active-high reset
//   in_data  : upstream payload
//   in_vld   : upstream valid
//   in_rdy   : registered ready, high whenever fewer than two entries are held
//   out_data : head payload (the incoming beat itself when the buffer is empty)
//   out_vld  : head valid
//   out_rdy  : downstream takes the head when out_vld & out_rdy
module full_skid_buf #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic reset,
   input  T     in_data,
   input  logic in_vld,
   output logic in_rdy,
   output T     out_data,
   output logic out_vld,
   input  logic out_rdy
);

   T           mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic [1:0] count_nxt;
   logic       in_fire;
   logic       out_fire;
   logic       bypass;
   logic       push;
   logic       pop;

   // With nothing stored the incoming beat is presented straight away, so an
   // accepted beat can reach the consumer in the same cycle it is accepted.
   assign bypass    = (count == 2'd0);
   assign in_fire   = in_vld & in_rdy;
   assign out_vld   = ~bypass | in_fire;
   assign out_data  = bypass ? in_data : mem[rd_ptr];
   assign out_fire  = out_vld & out_rdy;
   assign push      = in_fire & ~(bypass & out_fire);
   assign pop       = out_fire & ~bypass;
   assign count_nxt = count + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         in_rdy <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
         end
         wr_ptr <= wr_ptr ^ push;
         rd_ptr <= rd_ptr ^ pop;
         count  <= count_nxt;
         in_rdy <= (count_nxt != 2'd2);
      end
   end

endmodule

// File: rtl/full_tap_loader.sv
// Distributes the serial tap stream over NUM_STAGES stages, TAPS_PER_STAGE
// taps each, in stage order, through one registered output slot.
//   clk, reset     : clock, asynchronous active-high reset
//   tap_in*        : incoming tap stream (vld/rdy, fst marks a new load)
//   stage_tap      : tap word, shared bus to all stages
//   stage_tap_fst  : first tap for the addressed stage
//   stage_tap_vld  : one-hot valid, bit i addresses stage i
//   stage_tap_rdy  : per-stage ready; only the addressed bit is used
//   load_finish    : level, high once the final tap has left the slot
//   tap_err        : sticky framing error, present only with FULL_TAP_LOADER_ERR_EN
//
// state | meaning
// IDLE  | no load since reset; fst=0 beats are dropped
// LOAD  | forwarding taps to stage_idx, tap_cnt taps already sent to it
// DONE  | every stage loaded; fst=0 beats are dropped, fst=1 restarts
module full_tap_loader
   import full_tap_loader_pkg::*;
#(
   parameter int NUM_STAGES     = 2,
   parameter int TAPS_PER_STAGE = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  float_24_8             tap_in,
   input  logic                  tap_in_fst,
   input  logic                  tap_in_vld,
   output logic                  tap_in_rdy,
   output float_24_8             stage_tap,
   output logic                  stage_tap_fst,
   output logic [NUM_STAGES-1:0] stage_tap_vld,
   input  logic [NUM_STAGES-1:0] stage_tap_rdy,
   output logic                  load_finish
`ifdef FULL_TAP_LOADER_ERR_EN
   ,
   output logic                  tap_err
`endif
);

   localparam int TCNT_W = (TAPS_PER_STAGE > 1) ? $clog2(TAPS_PER_STAGE) : 1;
   localparam int SIDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [TCNT_W-1:0]     LAST_TAP   = TCNT_W'(TAPS_PER_STAGE - 1);
   localparam logic [SIDX_W-1:0]     LAST_STAGE = SIDX_W'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

   full_tap_loader_state_t state, state_nxt;
   logic [SIDX_W-1:0] stage_idx, stage_idx_nxt;
   logic [TCNT_W-1:0] tap_cnt, tap_cnt_nxt;

   tap_beat_t in_beat;
   tap_beat_t head_beat;
   logic      head_vld;
   logic      head_rdy;
   logic      pop;
   logic      slot_drain;
   logic      slot_free;
   logic      slot_last;

   logic              fwd;
   logic [SIDX_W-1:0] fwd_stage;
   logic              fwd_fst;
   logic              fwd_last;
   logic              restart;
   logic              frame_err;

   assign in_beat = '{data: tap_in, fst: tap_in_fst};

   full_skid_buf #(
      .T(tap_beat_t)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .in_data (in_beat),
      .in_vld  (tap_in_vld),
      .in_rdy  (tap_in_rdy),
      .out_data(head_beat),
      .out_vld (head_vld),
      .out_rdy (head_rdy)
   );

   // The slot can take a new beat when empty or when its beat leaves this cycle.
   assign slot_drain = |(stage_tap_vld & stage_tap_rdy);
   assign slot_free  = ~|stage_tap_vld;
   assign head_rdy   = slot_free | slot_drain;
   assign pop        = head_vld & head_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         stage_idx <= '0;
         tap_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         stage_idx <= stage_idx_nxt;
         tap_cnt   <= tap_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      stage_idx_nxt = stage_idx;
      tap_cnt_nxt   = tap_cnt;
      fwd           = 1'b0;
      fwd_stage     = stage_idx;
      fwd_fst       = 1'b0;
      fwd_last      = 1'b0;
      restart       = 1'b0;
      frame_err     = 1'b0;
      if (pop) begin
         if (head_beat.fst) begin
            // A first tap always starts over at stage 0; it is tap 0 of that stage.
            restart       = 1'b1;
            frame_err     = (state == LOAD);
            fwd           = 1'b1;
            fwd_stage     = '0;
            fwd_fst       = 1'b1;
            stage_idx_nxt = '0;
            tap_cnt_nxt   = TCNT_W'(1);
            state_nxt     = LOAD;
         end else if (state == LOAD) begin
            fwd     = 1'b1;
            fwd_fst = (tap_cnt == '0);
            if (tap_cnt == LAST_TAP) begin
               tap_cnt_nxt = '0;
               if (stage_idx == LAST_STAGE) begin
                  fwd_last  = 1'b1;
                  state_nxt = DONE;
               end else begin
                  stage_idx_nxt = stage_idx + SIDX_W'(1);
               end
            end else begin
               tap_cnt_nxt = tap_cnt + TCNT_W'(1);
            end
         end else begin
            frame_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_tap     <= '0;
         stage_tap_fst <= 1'b0;
         stage_tap_vld <= '0;
         slot_last     <= 1'b0;
      end else if (fwd) begin
         stage_tap     <= head_beat.data;
         stage_tap_fst <= fwd_fst;
         stage_tap_vld <= STAGE_ONE << fwd_stage;
         slot_last     <= fwd_last;
      end else if (slot_drain) begin
         stage_tap_fst <= 1'b0;
         stage_tap_vld <= '0;
         slot_last     <= 1'b0;
      end
   end

   // A restart in the same cycle as the final drain belongs to the new load,
   // so the clear takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_finish <= 1'b0;
      end else if (restart) begin
         load_finish <= 1'b0;
      end else if (slot_drain && slot_last) begin
         load_finish <= 1'b1;
      end
   end

`ifdef FULL_TAP_LOADER_ERR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tap_err <= 1'b0;
      end else if (frame_err) begin
         tap_err <= 1'b1;
      end
   end
`endif

endmodule
